i2s_to_wb_fifo_seq: RTL
=======================

# i2s_to_wb_fifo_seq

Parametrised FIFO pop sequencer for the I2S-to-Wishbone receive/transmit path, successor to the two-channel left/right pop controller. Handshakes with the Wishbone-side FIFO (enable/ack), issues one-cycle pops routed to one of NUM_CH TDM slots, and resynchronises the slot counter to the I2S frame start. It adds an ack-wait timeout, sticky error reporting with explicit clear, and an optional saturating underrun counter. It sits in the i2s_clk_i domain between the I2S serialiser and the sample FIFO.

## Interface
- NUM_CH, default 2: TDM slots per frame, 2..16.
- ACK_TIMEOUT, default 64: max cycles in ACK_WAIT before error; 0 disables the timeout.
- ERR_CNT_W, default 8: underrun counter width.
- i2s_clk_i  in  1  clock; i2s_rst_i  in  1  asynchronous, active-high reset.
- i2s_ws_edge  in  1  one-cycle pulse on any WS transition.
- i2s_ws_i  in  1  current WS level; low at the edge marks frame start (slot 0).
- fifo_enable  in  1  sequencer enable.
- fifo_empty  in  1  FIFO empty flag, sampled in POP.
- fifo_ack  in  1  FIFO data-valid acknowledge.
- err_clr_i  in  1  one-cycle clear of sticky error and counter.
- fifo_pop  out  NUM_CH  one-hot pop, bit = current slot.
- fifo_slot_o  out  $clog2(NUM_CH)  current slot index.
- fifo_ready  out  1  high in ACK_WAIT.
- fifo_fsm_error  out  1  high in ERROR (one-cycle pulse per event).
- err_sticky_o  out  1  set on any error, cleared by err_clr_i.
- err_timeout_o  out  1  sticky, set when the error cause was a timeout.
- underrun_cnt_o  out  ERR_CNT_W  saturating underrun count (macro-dependent).

## Operation
- One-hot states IDLE=0001, ACK_WAIT=0010, POP=0100, ERROR=1000; illegal encodings go to ERROR next cycle.
- IDLE: fifo_enable & ~fifo_ack -> ACK_WAIT; else stay.
- ACK_WAIT: ~fifo_enable -> IDLE; fifo_ack -> POP; timeout counter == ACK_TIMEOUT-1 (ACK_TIMEOUT>0) -> ERROR with err_timeout_o set; else stay. Counter clears on ACK_WAIT entry.
- POP: fifo_pop[slot]=1 for exactly one cycle; fifo_empty -> ERROR (underrun); else IDLE. Slot advances on leaving POP, wrapping NUM_CH-1 -> 0.
- ERROR: fifo_fsm_error=1 for one cycle; next state ACK_WAIT if fifo_enable, else IDLE.
- Frame resync: i2s_ws_edge & ~i2s_ws_i forces slot to 0 next cycle; takes priority over the POP advance in the same cycle. For NUM_CH==2 the slot instead tracks WS directly (slot = i2s_ws_i), matching the legacy left/right mapping.
- err_clr_i coincident with a new error: the set wins.
- fifo_enable deasserting in POP or ERROR does not abort; the FSM returns to IDLE afterwards.

## Timing
- Reset: state IDLE, slot 0, all outputs 0, counters 0.
- Moore outputs only; fifo_pop asserts the cycle after fifo_ack is sampled high in ACK_WAIT.
- Minimum pop spacing is 3 cycles (IDLE, ACK_WAIT, POP).
- Reset mid-POP: fifo_pop drops asynchronously with i2s_rst_i.

## Configuration
- I2S_TO_WB_UNDERRUN_CNT_EN defined: underrun_cnt_o increments on every POP->ERROR underrun, saturates at all-ones and clears on err_clr_i. Timeouts are not counted.
- Not defined: the counter is not built and underrun_cnt_o is tied to 0. The port remains present.

## Structure
- Shared package i2s_to_wb_pkg holds the state localparams (IDLE/ACK_WAIT/POP/ERROR one-hot) and the error-cause encodings.
- One sub-module, i2s_to_wb_sat_cnt: a generic saturating counter with clear, used for the underrun count and the timeout counter.

## Test plan
- NUM_CH=4: enable, ack each cycle it is requested, fifo_empty=0 -> fifo_pop sequence 0001,0010,0100,1000,0001, spaced 3 cycles apart.
- fifo_empty=1 during POP -> fifo_fsm_error pulses 1 cycle, err_sticky_o=1, underrun_cnt_o=1 (macro on) or 0 (macro off), next state ACK_WAIT.
- ACK_TIMEOUT=8, no ack -> fifo_ready high 8 cycles, then ERROR, err_timeout_o=1; err_clr_i clears both sticky flags.
- WS falling edge while slot=2 and in POP -> pop on bit 2, next slot 0.
- 300 underruns with ERR_CNT_W=8 -> underrun_cnt_o=255; err_clr_i together with an underrun -> counter=1.
- Assert i2s_rst_i mid-POP -> fifo_pop=0 immediately; after release state IDLE, slot 0.

Source files
------------

// File: rtl/i2s_to_wb_pkg.sv
// Shared definitions for the I2S-to-Wishbone FIFO pop sequencer:
// one-hot FSM state encodings and error-cause codes.
package i2s_to_wb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'b0001,
    ST_ACK_WAIT = 4'b0010,
    ST_POP      = 4'b0100,
    ST_ERROR    = 4'b1000
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_TIMEOUT  = 2'd1,
    CAUSE_UNDERRUN = 2'd2,
    CAUSE_ILLEGAL  = 2'd3
  } err_cause_t;

endpackage

// File: rtl/i2s_to_wb_sat_cnt.sv
// Generic saturating up-counter with synchronous clear; a clear
// coinciding with an increment restarts the count at one.
module i2s_to_wb_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_r;

  // Count register: clear/increment priority, holds at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {W{1'b0}};
    end else if (clr && inc) begin
      cnt_r <= W'(1'b1);
    end else if (clr) begin
      cnt_r <= {W{1'b0}};
    end else if (inc && !(&cnt_r)) begin
      cnt_r <= cnt_r + W'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/i2s_to_wb_fifo_seq.sv
// FIFO pop sequencer: handshakes with the sample FIFO, pops one TDM slot at a time,
// resyncs to WS frame start. Define I2S_TO_WB_UNDERRUN_CNT_EN to build the underrun counter.
module i2s_to_wb_fifo_seq
  import i2s_to_wb_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int ACK_TIMEOUT = 64,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                      i2s_clk_i,
  input  logic                      i2s_rst_i,
  input  logic                      i2s_ws_edge,
  input  logic                      i2s_ws_i,
  input  logic                      fifo_enable,
  input  logic                      fifo_empty,
  input  logic                      fifo_ack,
  input  logic                      err_clr_i,
  output logic [NUM_CH-1:0]         fifo_pop,
  output logic [$clog2(NUM_CH)-1:0] fifo_slot_o,
  output logic                      fifo_ready,
  output logic                      fifo_fsm_error,
  output logic                      err_sticky_o,
  output logic                      err_timeout_o,
  output logic [ERR_CNT_W-1:0]      underrun_cnt_o
);

  localparam int SW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  state_t            state_r, state_n;
  err_cause_t        err_cause_s;
  logic [SW-1:0]     slot_r, slot_n;
  logic [NUM_CH-1:0] pop_r, pop_n;
  logic              ready_r, error_r;
  logic              sticky_r, timeout_r;
  logic [TO_W-1:0]   to_cnt_s;
  logic              to_hit_s;

  // Counts cycles spent in ACK_WAIT; held at zero in every other state.
  i2s_to_wb_sat_cnt #(.W(TO_W)) u_to_cnt (
    .clk (i2s_clk_i),
    .rst (i2s_rst_i),
    .clr (state_r != ST_ACK_WAIT),
    .inc (state_r == ST_ACK_WAIT),
    .cnt (to_cnt_s)
  );

  assign to_hit_s = (ACK_TIMEOUT > 0) && (to_cnt_s == TO_W'(ACK_TIMEOUT - 1));

  // Next-state and error-cause decode; corrupted encodings fall into ERROR.
  always_comb begin
    state_n     = state_r;
    err_cause_s = CAUSE_NONE;
    case (state_r)
      ST_IDLE: begin
        if (fifo_enable && !fifo_ack) state_n = ST_ACK_WAIT;
        else                          state_n = ST_IDLE;
      end
      ST_ACK_WAIT: begin
        if (!fifo_enable) begin
          state_n = ST_IDLE;
        end else if (fifo_ack) begin
          state_n = ST_POP;
        end else if (to_hit_s) begin
          state_n     = ST_ERROR;
          err_cause_s = CAUSE_TIMEOUT;
        end else begin
          state_n = ST_ACK_WAIT;
        end
      end
      ST_POP: begin
        if (fifo_empty) begin
          state_n     = ST_ERROR;
          err_cause_s = CAUSE_UNDERRUN;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_ERROR: begin
        if (fifo_enable) state_n = ST_ACK_WAIT;
        else             state_n = ST_IDLE;
      end
      default: begin
        state_n     = ST_ERROR;
        err_cause_s = CAUSE_ILLEGAL;
      end
    endcase
  end

  // Slot selection: two-slot builds follow WS like the legacy L/R path,
  // wider builds resync on frame start ahead of the post-POP advance.
  always_comb begin
    slot_n = slot_r;
    if (NUM_CH == 2) begin
      slot_n = SW'(i2s_ws_i);
    end else if (i2s_ws_edge && !i2s_ws_i) begin
      slot_n = {SW{1'b0}};
    end else if (state_r == ST_POP) begin
      if (slot_r == SW'(NUM_CH - 1)) slot_n = {SW{1'b0}};
      else                           slot_n = slot_r + SW'(1'b1);
    end else begin
      slot_n = slot_r;
    end
  end

  // Outputs are registered from next-state values so they stay Moore-timed.
  always_comb begin
    pop_n = {NUM_CH{1'b0}};
    if (state_n == ST_POP) pop_n = NUM_CH'(1'b1) << slot_n;
    else                   pop_n = {NUM_CH{1'b0}};
  end

  // State, slot and handshake output registers.
  always_ff @(posedge i2s_clk_i or posedge i2s_rst_i) begin
    if (i2s_rst_i) begin
      state_r <= ST_IDLE;
      slot_r  <= {SW{1'b0}};
      pop_r   <= {NUM_CH{1'b0}};
      ready_r <= 1'b0;
      error_r <= 1'b0;
    end else begin
      state_r <= state_n;
      slot_r  <= slot_n;
      pop_r   <= pop_n;
      ready_r <= (state_n == ST_ACK_WAIT);
      error_r <= (state_n == ST_ERROR);
    end
  end

  // Sticky error flags; a new error outranks a simultaneous clear.
  always_ff @(posedge i2s_clk_i or posedge i2s_rst_i) begin
    if (i2s_rst_i) begin
      sticky_r  <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      if (err_cause_s != CAUSE_NONE) sticky_r <= 1'b1;
      else if (err_clr_i)            sticky_r <= 1'b0;
      if (err_cause_s == CAUSE_TIMEOUT) timeout_r <= 1'b1;
      else if (err_clr_i)               timeout_r <= 1'b0;
    end
  end

`ifdef I2S_TO_WB_UNDERRUN_CNT_EN
  i2s_to_wb_sat_cnt #(.W(ERR_CNT_W)) u_underrun_cnt (
    .clk (i2s_clk_i),
    .rst (i2s_rst_i),
    .clr (err_clr_i),
    .inc (err_cause_s == CAUSE_UNDERRUN),
    .cnt (underrun_cnt_o)
  );
`else
  assign underrun_cnt_o = {ERR_CNT_W{1'b0}};
`endif

  assign fifo_pop       = pop_r;
  assign fifo_slot_o    = slot_r;
  assign fifo_ready     = ready_r;
  assign fifo_fsm_error = error_r;
  assign err_sticky_o   = sticky_r;
  assign err_timeout_o  = timeout_r;

endmodule
